particle_updater: RTL and testbench

PARTICLE_UPDATER -- requirements
Module: particle_updater

---
 rtl/particle_updater.sv | 124 ++++++++++++
 tb/tb_particle_updater.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/particle_updater.sv
// Single-particle physics step: gravity on velocity, position integration,
// floor/ceiling bounce with damping, then one write-back to particle memory.
module particle_updater #(
  parameter int ADDR_WIDTH            = 2,
  parameter int DATA_WIDTH            = 16,
  parameter int PARTICLE_COUNTER_SIZE = 2,
  parameter int GRAVITY               = 1,
  parameter int POS_MAX               = 200,
  parameter int DAMP_SHIFT            = 1
) (
  input  logic                             clk_in,
  input  logic                             rst_n,
  input  logic                             trigger_update,
  input  logic [DATA_WIDTH-1:0]            particle_in,
  input  logic [PARTICLE_COUNTER_SIZE-1:0] particle_idx,
  output logic [ADDR_WIDTH-1:0]            addr_out,
  output logic [DATA_WIDTH-1:0]            mem_out,
  output logic                             mem_enable,
  output logic                             mem_write_enable,
  output logic                             update_finished,
  output logic                             busy
);

  localparam int HW   = DATA_WIDTH / 2;
  localparam int SW   = HW + 2;
  localparam int VMIN = -(2 ** (HW - 1));
  localparam int VMAX = (2 ** (HW - 1)) - 1;

  typedef enum logic [2:0] {IDLE, VEL, POS, WRITE, DONE} state_t;

  state_t state, next_state;

  logic [DATA_WIDTH-1:0]            part_q;
  logic [PARTICLE_COUNTER_SIZE-1:0] idx_q;
  logic signed [HW-1:0]             v1_q;
  logic [DATA_WIDTH-1:0]            res_q;

  logic signed [HW-1:0]  v_in;
  int                    v_dec;
  logic signed [HW-1:0]  v1_next;
  logic signed [SW-1:0]  s_sum;
  logic signed [HW:0]    v1_ext;
  logic [HW:0]           v1_abs;
  logic [HW:0]           v1_mag;
  logic [DATA_WIDTH-1:0] res_next;

  // State register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; DONE stays until the done pulse has been emitted so
  // that the pulse cycle still reads as busy and IDLE is reached one edge later.
  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (trigger_update) next_state = VEL;
      VEL:     next_state = POS;
      POS:     next_state = WRITE;
      WRITE:   next_state = DONE;
      DONE:    if (update_finished) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Gravity with saturation, integration, and bounce resolution
  always_comb begin
    v_in   = part_q[HW-1:0];
    v_dec  = int'(v_in) - GRAVITY;
    if (v_dec < VMIN)      v1_next = HW'(VMIN);
    else if (v_dec > VMAX) v1_next = HW'(VMAX);
    else                   v1_next = HW'(v_dec);

    s_sum  = $signed({2'b00, part_q[DATA_WIDTH-1:HW]}) + SW'(v1_q);
    v1_ext = (HW + 1)'(v1_q);
    v1_abs = v1_ext[HW] ? (HW + 1)'(-v1_ext) : (HW + 1)'(v1_ext);
    v1_mag = v1_abs >> DAMP_SHIFT;

    if (s_sum[SW-1])
      res_next = {HW'(0), v1_mag[HW-1:0]};
    else if (s_sum > SW'(POS_MAX))
      res_next = {HW'(POS_MAX), HW'(-v1_mag)};
    else
      res_next = {s_sum[HW-1:0], v1_q};
  end

  // Datapath registers and registered memory/handshake outputs
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      part_q           <= '0;
      idx_q            <= '0;
      v1_q             <= '0;
      res_q            <= '0;
      addr_out         <= '0;
      mem_out          <= '0;
      mem_enable       <= 1'b0;
      mem_write_enable <= 1'b0;
      update_finished  <= 1'b0;
    end else begin
      mem_enable       <= 1'b0;
      mem_write_enable <= 1'b0;
      update_finished  <= 1'b0;
      case (state)
        IDLE: if (trigger_update) begin
          part_q <= particle_in;
          idx_q  <= particle_idx;
        end
        VEL:   v1_q  <= v1_next;
        POS:   res_q <= res_next;
        WRITE: begin
          mem_enable       <= 1'b1;
          mem_write_enable <= 1'b1;
          addr_out         <= ADDR_WIDTH'(idx_q);
          mem_out          <= res_q;
        end
        DONE:  update_finished <= !update_finished;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_particle_updater.sv
module tb_particle_updater;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b1;
  logic        trigger_update = 1'b0;
  logic [15:0] particle_in = '0;
  logic [1:0]  particle_idx = '0;
  logic [1:0]  addr_out;
  logic [15:0] mem_out;
  logic        mem_enable, mem_write_enable, update_finished, busy;

  int passed = 0;
  int total  = 0;
  int writes = 0;
  int dones  = 0;

  particle_updater #(
    .ADDR_WIDTH(2), .DATA_WIDTH(16), .PARTICLE_COUNTER_SIZE(2),
    .GRAVITY(1), .POS_MAX(200), .DAMP_SHIFT(1)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .trigger_update(trigger_update),
    .particle_in(particle_in), .particle_idx(particle_idx),
    .addr_out(addr_out), .mem_out(mem_out), .mem_enable(mem_enable),
    .mem_write_enable(mem_write_enable), .update_finished(update_finished),
    .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (mem_enable) writes++;
    if (update_finished) dones++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Full update: trigger sampled at E0, write visible after E3, done after E4
  task automatic run_update(input string tag, input logic [15:0] pin,
                            input logic [1:0] idx, input logic [15:0] exp_word);
    particle_in    = pin;
    particle_idx   = idx;
    trigger_update = 1'b1;
    tick();                         // E0
    trigger_update = 1'b0;
    chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
    chk({tag, "_men_e0"}, 32'(mem_enable), 32'd0);
    tick();                         // E1
    tick();                         // E2
    chk({tag, "_men_e2"}, 32'(mem_enable), 32'd0);
    tick();                         // E3
    chk({tag, "_men_e3"}, 32'(mem_enable), 32'd1);
    chk({tag, "_we_e3"}, 32'(mem_write_enable), 32'd1);
    chk({tag, "_addr_e3"}, 32'(addr_out), 32'(idx));
    chk({tag, "_data_e3"}, 32'(mem_out), 32'(exp_word));
    chk({tag, "_done_e3"}, 32'(update_finished), 32'd0);
    tick();                         // E4
    chk({tag, "_men_e4"}, 32'(mem_enable), 32'd0);
    chk({tag, "_done_e4"}, 32'(update_finished), 32'd1);
    chk({tag, "_busy_e4"}, 32'(busy), 32'd1);
    chk({tag, "_hold_e4"}, 32'(mem_out), 32'(exp_word));
    tick();                         // E5
    chk({tag, "_done_e5"}, 32'(update_finished), 32'd0);
    chk({tag, "_busy_e5"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int held_writes;
    // Reset before the first clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_men", 32'(mem_enable), 32'd0);
    chk("rst_we", 32'(mem_write_enable), 32'd0);
    chk("rst_done", 32'(update_finished), 32'd0);
    chk("rst_addr", 32'(addr_out), 32'd0);
    chk("rst_data", 32'(mem_out), 32'd0);
    tick();
    tick();
    @(negedge clk_in);
    rst_n = 1'b1;

    // First edge after release accepts the trigger
    run_update("free", 16'h6405, 2'd2, 16'h6804);
    run_update("floor", 16'h03FA, 2'd0, 16'h0003);
    run_update("ceil", 16'hC60A, 2'd3, 16'hC8FC);
    run_update("vsat", 16'h9680, 2'd1, 16'h1680);
    run_update("bound", 16'hC801, 2'd2, 16'hC800);

    // Trigger held high across 10 sampling edges E0..E9
    particle_in    = 16'hC60A;
    particle_idx   = 2'd1;
    trigger_update = 1'b1;
    held_writes    = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 9) trigger_update = 1'b0;
      if (i < 9 && mem_enable) held_writes++;
      if (i == 3) chk("held_men_e3", 32'(mem_enable), 32'd1);
      if (i == 5) chk("held_busy_e5", 32'(busy), 32'd0);
      if (i == 6) chk("held_busy_e6", 32'(busy), 32'd1);
      if (i == 9) begin
        chk("held_men_e9", 32'(mem_enable), 32'd1);
        chk("held_data_e9", 32'(mem_out), 32'hC8FC);
      end
    end
    chk("held_writes", 32'(held_writes), 32'd1);
    tick();
    tick();
    chk("held_idle", 32'(busy), 32'd0);

    // Reset between E2 and E3 aborts the update
    particle_in    = 16'h03FA;
    particle_idx   = 2'd3;
    trigger_update = 1'b1;
    tick();
    trigger_update = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_men", 32'(mem_enable), 32'd0);
    chk("abort_we", 32'(mem_write_enable), 32'd0);
    chk("abort_done", 32'(update_finished), 32'd0);
    chk("abort_addr", 32'(addr_out), 32'd0);
    chk("abort_data", 32'(mem_out), 32'd0);
    tick();
    tick();
    tick();
    chk("abort_men_held", 32'(mem_enable), 32'd0);
    @(negedge clk_in);
    rst_n = 1'b1;
    run_update("post_rst", 16'h6405, 2'd2, 16'h6804);

    tick();
    tick();
    chk("total_writes", 32'(writes), 32'd8);
    chk("total_dones", 32'(dones), 32'd8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
